// File: rtl/nic_host_agent_pkg.sv
// Shared definitions for the NIC host agent: NIC register map and agent state encodings.
package nic_host_agent_pkg;

  localparam logic [1:0] NIC_ADDR_RXBUF  = 2'b00;
  localparam logic [1:0] NIC_ADDR_RXSTAT = 2'b01;
  localparam logic [1:0] NIC_ADDR_TXBUF  = 2'b10;
  localparam logic [1:0] NIC_ADDR_TXSTAT = 2'b11;
  localparam int unsigned NIC_STAT_FULL_BIT = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL_RX,
    S_READ_RX,
    S_DELIVER,
    S_POLL_TX,
    S_WRITE_TX
  } agent_state_e;

  typedef enum logic {
    SVC_RX,
    SVC_TX
  } service_e;

endpackage

// File: rtl/nic_host_agent_sat_counter.sv
// Event counter that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/nic_host_agent.sv
// Host-side NIC CPU-port initiator: drains the NIC RX buffer and fills the TX buffer,
// alternating fairly between the two services.
module nic_host_agent
  import nic_host_agent_pkg::*;
#(
  parameter int unsigned PACKET_WIDTH = 64,
  parameter int unsigned POLL_GAP     = 0,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    tx_valid,
  input  logic [PACKET_WIDTH-1:0] tx_pkt,
  output logic                    tx_ready,
  output logic                    rx_valid,
  output logic [PACKET_WIDTH-1:0] rx_pkt,
  input  logic                    rx_ready,
  output logic [1:0]              addr,
  output logic [PACKET_WIDTH-1:0] d_in,
  input  logic [PACKET_WIDTH-1:0] d_out,
  output logic                    nicEn,
  output logic                    nicEnWR,
  output logic [CNT_WIDTH-1:0]    tx_count,
  output logic [CNT_WIDTH-1:0]    rx_count
);

  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP);

  agent_state_e            state_q;
  service_e                last_q;
  logic [7:0]              gap_q;
  logic                    rx_valid_q;
  logic [PACKET_WIDTH-1:0] rx_pkt_q;
  logic                    tx_inc;
  logic                    rx_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      last_q     <= SVC_TX;
      gap_q      <= '0;
      rx_valid_q <= 1'b0;
      rx_pkt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // gap_q parks at GAP_LAST while disabled so re-enabling starts at once
          if (gap_q != GAP_LAST) begin
            gap_q <= gap_q + 8'd1;
          end else if (enable) begin
            gap_q <= '0;
            if (tx_valid && (last_q == SVC_RX)) state_q <= S_POLL_TX;
            else                                state_q <= S_POLL_RX;
          end
        end
        S_POLL_RX: begin
          if (d_out[NIC_STAT_FULL_BIT]) begin
            state_q <= S_READ_RX;
          end else begin
            last_q  <= SVC_RX;
            state_q <= S_IDLE;
          end
        end
        S_READ_RX: begin
          rx_pkt_q   <= d_out;
          rx_valid_q <= 1'b1;
          state_q    <= S_DELIVER;
        end
        S_DELIVER: begin
          if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
            last_q     <= SVC_RX;
            state_q    <= S_IDLE;
          end
        end
        S_POLL_TX: begin
          if (!d_out[NIC_STAT_FULL_BIT]) begin
            state_q <= S_WRITE_TX;
          end else begin
            last_q  <= SVC_TX;
            state_q <= S_IDLE;
          end
        end
        S_WRITE_TX: begin
          last_q  <= SVC_TX;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // NIC side is a Moore decode of state; the write is additionally gated by tx_valid
  always_comb begin
    addr     = '0;
    d_in     = '0;
    nicEn    = 1'b0;
    nicEnWR  = 1'b0;
    tx_ready = 1'b0;
    case (state_q)
      S_POLL_RX: begin
        nicEn = 1'b1;
        addr  = NIC_ADDR_RXSTAT;
      end
      S_READ_RX: begin
        nicEn = 1'b1;
        addr  = NIC_ADDR_RXBUF;
      end
      S_POLL_TX: begin
        nicEn = 1'b1;
        addr  = NIC_ADDR_TXSTAT;
      end
      S_WRITE_TX: begin
        if (tx_valid) begin
          nicEn    = 1'b1;
          nicEnWR  = 1'b1;
          addr     = NIC_ADDR_TXBUF;
          d_in     = tx_pkt;
          tx_ready = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign tx_inc   = (state_q == S_WRITE_TX) && tx_valid;
  assign rx_inc   = (state_q == S_READ_RX);
  assign rx_valid = rx_valid_q;
  assign rx_pkt   = rx_pkt_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_tx_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (tx_inc),
    .count (tx_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_rx_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (rx_inc),
    .count (rx_count)
  );

endmodule

// File: tb/tb_nic_host_agent.sv
// Directed bench for nic_host_agent with a combinational NIC register model.
module tb_nic_host_agent;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        tx_valid = 1'b0;
  logic [63:0] tx_pkt = '0;
  logic        tx_ready;
  logic        rx_valid;
  logic [63:0] rx_pkt;
  logic        rx_ready = 1'b1;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicEnWR;
  logic [1:0]  tx_count;
  logic [1:0]  rx_count;

  logic        rx_full = 1'b0;
  logic        tx_full = 1'b0;
  logic [63:0] rx_buf  = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nic_host_agent #(
    .PACKET_WIDTH (64),
    .POLL_GAP     (0),
    .CNT_WIDTH    (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .tx_valid (tx_valid),
    .tx_pkt   (tx_pkt),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_pkt   (rx_pkt),
    .rx_ready (rx_ready),
    .addr     (addr),
    .d_in     (d_in),
    .d_out    (d_out),
    .nicEn    (nicEn),
    .nicEnWR  (nicEnWR),
    .tx_count (tx_count),
    .rx_count (rx_count)
  );

  always_comb begin
    d_out = '0;
    case (addr)
      2'b00: d_out = rx_buf;
      2'b01: d_out[0] = rx_full;
      2'b11: d_out[0] = tx_full;
      default: ;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tx_valid = 1'b0; rx_full = 1'b0; tx_full = 1'b0; rx_ready = 1'b1;
    reset = 1'b1;
    step();
    tests++;
    if ({nicEn, nicEnWR, addr, tx_ready, rx_valid} !== 6'b0) begin
      fails++; $display("FAIL reset_outputs: got en=%b wr=%b addr=%b txr=%b rxv=%b, want all 0", nicEn, nicEnWR, addr, tx_ready, rx_valid);
    end
    tests++;
    if (d_in !== 64'h0 || rx_pkt !== 64'h0) begin
      fails++; $display("FAIL reset_data: got d_in=%h rx_pkt=%h, want 0", d_in, rx_pkt);
    end
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (nicEn !== i[0] || addr !== (i[0] ? 2'b01 : 2'b00)) begin
        fails++; $display("FAIL idle_poll[%0d]: got en=%b addr=%b, want en=%b addr=%b", i, nicEn, addr, i[0], (i[0] ? 2'b01 : 2'b00));
      end
      step();
    end
    tests++;
    if (tx_count !== 2'd0 || rx_count !== 2'd0) begin
      fails++; $display("FAIL idle_counts: got tx=%0d rx=%0d, want 0 0", tx_count, rx_count);
    end
  endtask

  task automatic test_rx();
    tx_valid = 1'b0; rx_full = 1'b1; rx_ready = 1'b1; rx_buf = 64'hDEAD_BEEF_0000_0001;
    apply_reset();
    step();
    tests++;
    if (nicEn !== 1'b1 || nicEnWR !== 1'b0 || addr !== 2'b01) begin
      fails++; $display("FAIL rx_poll: got en=%b wr=%b addr=%b, want 1 0 01", nicEn, nicEnWR, addr);
    end
    step();
    tests++;
    if (nicEn !== 1'b1 || addr !== 2'b00 || rx_valid !== 1'b0) begin
      fails++; $display("FAIL rx_read: got en=%b addr=%b rxv=%b, want 1 00 0", nicEn, addr, rx_valid);
    end
    rx_full = 1'b0;
    step();
    tests++;
    if (rx_valid !== 1'b1 || rx_pkt !== 64'hDEAD_BEEF_0000_0001 || nicEn !== 1'b0) begin
      fails++; $display("FAIL rx_deliver: got rxv=%b pkt=%h en=%b, want 1 deadbeef00000001 0", rx_valid, rx_pkt, nicEn);
    end
    tests++;
    if (rx_count !== 2'd1) begin
      fails++; $display("FAIL rx_count: got %0d, want 1", rx_count);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (rx_valid !== 1'b0) begin
        fails++; $display("FAIL rx_valid_pulse[%0d]: got %b, want 0", i, rx_valid);
      end
    end
    tests++;
    if (rx_count !== 2'd1) begin
      fails++; $display("FAIL rx_count_hold: got %0d, want 1", rx_count);
    end
  endtask

  task automatic test_tx();
    tx_valid = 1'b1; tx_pkt = 64'h8000_0000_0000_00AA; tx_full = 1'b0; rx_full = 1'b0;
    apply_reset();
    step();
    step();
    step();
    tests++;
    if (nicEn !== 1'b1 || nicEnWR !== 1'b0 || addr !== 2'b11 || d_in !== 64'h0 || tx_ready !== 1'b0) begin
      fails++; $display("FAIL tx_poll: got en=%b wr=%b addr=%b d_in=%h txr=%b, want 1 0 11 0 0", nicEn, nicEnWR, addr, d_in, tx_ready);
    end
    step();
    tests++;
    if (nicEn !== 1'b1 || nicEnWR !== 1'b1 || addr !== 2'b10 || d_in !== 64'h8000_0000_0000_00AA || tx_ready !== 1'b1) begin
      fails++; $display("FAIL tx_write: got en=%b wr=%b addr=%b d_in=%h txr=%b, want 1 1 10 80000000000000aa 1", nicEn, nicEnWR, addr, d_in, tx_ready);
    end
    step();
    tx_valid = 1'b0;
    tests++;
    if (tx_ready !== 1'b0 || nicEn !== 1'b0 || tx_count !== 2'd1) begin
      fails++; $display("FAIL tx_after: got txr=%b en=%b cnt=%0d, want 0 0 1", tx_ready, nicEn, tx_count);
    end
  endtask

  task automatic test_alternate();
    logic       exp_en   [13] = '{0, 1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0};
    logic [1:0] exp_addr [13] = '{0, 1, 0, 0, 0, 3, 0, 1, 0, 0, 0, 3, 0};
    int writes;
    logic wrote;
    tx_valid = 1'b1; tx_pkt = 64'h0000_0000_0000_0055; tx_full = 1'b1; rx_full = 1'b1;
    rx_ready = 1'b1; rx_buf = 64'h1111_2222_3333_4444;
    apply_reset();
    for (int i = 0; i < 13; i++) begin
      tests++;
      if (nicEn !== exp_en[i] || addr !== exp_addr[i] || nicEnWR !== 1'b0) begin
        fails++; $display("FAIL alt_seq[%0d]: got en=%b addr=%b wr=%b, want en=%b addr=%b wr=0", i, nicEn, addr, nicEnWR, exp_en[i], exp_addr[i]);
      end
      if (i < 12) step();
    end
    tests++;
    if (rx_count !== 2'd2 || tx_count !== 2'd0) begin
      fails++; $display("FAIL alt_counts: got rx=%0d tx=%0d, want 2 0", rx_count, tx_count);
    end
    tx_full = 1'b0; rx_full = 1'b0;
    writes = 0; wrote = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (wrote) tx_valid = 1'b0;
      wrote = nicEn && nicEnWR;
      if (wrote) writes++;
    end
    tests++;
    if (writes !== 1 || tx_count !== 2'd1) begin
      fails++; $display("FAIL alt_release: got writes=%0d tx=%0d, want 1 1", writes, tx_count);
    end
  endtask

  task automatic test_backpressure();
    tx_valid = 1'b0; rx_full = 1'b1; rx_ready = 1'b0; rx_buf = 64'h0123_4567_89AB_CDEF;
    apply_reset();
    step();
    step();
    rx_full = 1'b0;
    step();
    rx_buf = 64'hFFFF_0000_FFFF_0000;
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (nicEn !== 1'b0 || rx_valid !== 1'b1 || rx_pkt !== 64'h0123_4567_89AB_CDEF) begin
        fails++; $display("FAIL bp_hold[%0d]: got en=%b rxv=%b pkt=%h, want 0 1 0123456789abcdef", i, nicEn, rx_valid, rx_pkt);
      end
      step();
    end
    rx_ready = 1'b1;
    tests++;
    if (rx_valid !== 1'b1) begin
      fails++; $display("FAIL bp_handshake: got rxv=%b, want 1", rx_valid);
    end
    step();
    tests++;
    if (rx_valid !== 1'b0 || nicEn !== 1'b0) begin
      fails++; $display("FAIL bp_idle: got rxv=%b en=%b, want 0 0", rx_valid, nicEn);
    end
    step();
    tests++;
    if (nicEn !== 1'b1 || addr !== 2'b01) begin
      fails++; $display("FAIL bp_repoll: got en=%b addr=%b, want 1 01", nicEn, addr);
    end
  endtask

  task automatic test_reset_mid_tx();
    int writes;
    tx_valid = 1'b1; tx_pkt = 64'hCAFE_0000_0000_0007; tx_full = 1'b0; rx_full = 1'b0; rx_ready = 1'b1;
    apply_reset();
    step(); step(); step(); step();
    tests++;
    if (nicEnWR !== 1'b1 || tx_ready !== 1'b1) begin
      fails++; $display("FAIL midtx_setup: got wr=%b txr=%b, want 1 1", nicEnWR, tx_ready);
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({nicEn, nicEnWR, addr, tx_ready, rx_valid} !== 6'b0 || d_in !== 64'h0 || tx_count !== 2'd0) begin
      fails++; $display("FAIL midtx_reset: got en=%b wr=%b addr=%b txr=%b rxv=%b d_in=%h cnt=%0d, want all 0", nicEn, nicEnWR, addr, tx_ready, rx_valid, d_in, tx_count);
    end
    step();
    reset = 1'b0;
    writes = 0;
    for (int i = 0; i < 100 && writes < 5; i++) begin
      step();
      if (nicEn && nicEnWR) writes++;
    end
    step();
    tx_valid = 1'b0;
    tests++;
    if (writes !== 5 || tx_count !== 2'd3) begin
      fails++; $display("FAIL tx_saturate: got writes=%0d cnt=%0d, want 5 3", writes, tx_count);
    end
  endtask

  initial begin
    test_reset();
    test_rx();
    test_tx();
    test_alternate();
    test_backpressure();
    test_reset_mid_tx();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units, want completion");
    $fatal(1, "timeout");
  end

endmodule
